evt_sync_rx: RTL
================

EVT_SYNC_RX -- requirements
Module: evt_sync_rx

Interface
REQ-001 SHALL have parameter C_NUM_CH, default 8, number of independent event channels (1..32).
REQ-002 SHALL have parameter C_SYNC_STAGES, default 2, metastability flops per channel (2..4).
REQ-003 SHALL have parameter C_CNT_W, default 8, width of each per-channel event counter (1..16).
REQ-004 SHALL have port rclk  input  1  sole clock; one clock; all state updates on posedge rclk.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port tog_in  input  C_NUM_CH  asynchronous per-channel toggle lines from the remote domain; one event per level change.
REQ-007 SHALL have port clr  input  C_NUM_CH  write-1-to-clear strobe for sts, ovf and counter of each channel.
REQ-008 SHALL have port irq_mask  input  C_NUM_CH  1 = channel enabled for irq.
REQ-009 SHALL have port cnt_sel  input  clog2(C_NUM_CH), minimum 1  counter readback channel index.
REQ-010 SHALL have port pulse  output  C_NUM_CH  one-cycle event strobe per channel.
REQ-011 SHALL have port sts  output  C_NUM_CH  sticky event flags.
REQ-012 SHALL have port ovf  output  C_NUM_CH  sticky flags: event arrived while sts already set.
REQ-013 SHALL have port irq  output  1  registered OR of (sts & irq_mask).
REQ-014 SHALL have port cnt_out  output  C_CNT_W  counter of channel cnt_sel.

Function
REQ-015 SHALL sample tog_in[i] through a C_SYNC_STAGES-deep flop chain followed by one history flop, all marked ASYNC_REG on the chain.
REQ-016 SHALL drive pulse[i] = last chain flop XOR history flop, with no combinational path from tog_in.
REQ-017 SHALL assert pulse[i] for exactly one cycle, visible after posedge C_SYNC_STAGES+1 counting the first edge sampling the new tog_in level.
REQ-018 SHALL produce one pulse per tog_in level change; changes closer than C_SYNC_STAGES+1 cycles apart are not guaranteed and are outside the contract.
REQ-019 SHALL set sts[i] on the edge after pulse[i]; clr[i] clears it; simultaneous pulse[i] and clr[i] leaves sts[i]=1 (no event lost).
REQ-020 SHALL set ovf[i] on the edge after pulse[i] when sts[i]=1 and clr[i]=0; clr[i] clears ovf[i]; set wins over clear only for sts, not ovf.
REQ-021 SHALL register irq one cycle after sts/irq_mask change.
REQ-022 SHALL increment counter[i] on pulse[i], saturating at 2^C_CNT_W-1; clr[i] sets it to 0, or to 1 if pulse[i] is simultaneous.
REQ-023 SHALL register cnt_out from counter[cnt_sel], one cycle latency; cnt_sel >= C_NUM_CH returns 0.
REQ-024 SHALL be a two-state priming FSM (PRIME, RUN): PRIME for C_SYNC_STAGES+1 cycles after rst deasserts, pulse forced 0 and history flops track chain; then RUN.

Reset
REQ-025 SHALL reset to 0 every chain, history, sts, ovf, counter, irq and cnt_out flop, and enter PRIME.
REQ-026 SHALL force pulse=0 while rst=1 and during PRIME, so a tog_in held at 1 across reset yields no event.
REQ-027 SHALL, on rst mid-event, discard the in-flight event without a later pulse.

Configuration
REQ-028 SHALL compile counters, cnt_sel decode and cnt_out register only when macro EVT_SYNC_CNT_EN is defined.
REQ-029 SHALL, without EVT_SYNC_CNT_EN, keep the cnt_sel/cnt_out ports, tie cnt_out to 0 and contain no counter flops; all other behaviour unchanged.

Structure
REQ-030 SHALL take C_SYNC_STAGES bounds, prime-length constant and FSM state encodings from shared package evt_sync_pkg.
REQ-031 SHALL instantiate per channel sub-module evt_sync_ch (chain, history, pulse, sts, ovf, counter); the top holds the FSM, irq and readback mux.

Verification
REQ-032 SHALL cover: C_SYNC_STAGES=2, tog_in[0] 0->1 in RUN -> pulse[0] high exactly one cycle, 3 edges later; sts[0]=1 next edge; irq=1 one edge after with irq_mask[0]=1.
REQ-033 SHALL cover: tog_in[3]=1 held through rst and release -> no pulse[3], sts[3]=0 after PRIME.
REQ-034 SHALL cover: two toggles on ch1 spaced 10 cycles, no clr -> sts[1]=1, ovf[1]=1, counter[1]=2 read via cnt_sel=1.
REQ-035 SHALL cover: clr[2] coincident with pulse[2] -> sts[2]=1, ovf[2]=0, counter[2]=1.
REQ-036 SHALL cover: C_CNT_W=2, five toggles on ch0 -> cnt_out=3 (saturated); irq_mask=0 -> irq stays 0 while sts[0]=1.
REQ-037 SHALL cover: build without EVT_SYNC_CNT_EN -> cnt_out=0 always; REQ-032..035 flag results unchanged.

Source files
------------

// File: rtl/evt_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : evt_sync_pkg
// Description : Shared constants, FSM encoding and helpers for evt_sync_rx.
// Revision    : 1.0 - initial release
// ============================================================================
package evt_sync_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    // Wide enough to count up to the longest prime window (SYNC_STAGES_MAX + 1).
    localparam int PRIME_CNT_W     = 3;

    typedef enum logic [0:0] {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } evt_state_e;

    function automatic int clamp_stages(input int stages);
        if (stages < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
        if (stages > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
        return stages;
    endfunction

    function automatic int prime_len(input int stages);
        return stages + 1;
    endfunction

    function automatic int sel_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage : evt_sync_pkg
`default_nettype wire

// File: rtl/evt_sync_ch.sv
`default_nettype none
// ============================================================================
// Module      : evt_sync_ch
// Description : One toggle-event channel: synchroniser, edge pulse, sticky
//               status/overflow and (with EVT_SYNC_CNT_EN) a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module evt_sync_ch
    import evt_sync_pkg::*;
#(
    parameter int C_SYNC_STAGES = 2,
    parameter int C_CNT_W       = 8
) (
    input  logic               rclk,
    input  logic               rst,
    input  logic               run_i,
    input  logic               tog_i,
    input  logic               clr_i,
    output logic               pulse_o,
    output logic               sts_o,
    output logic               ovf_o,
    output logic [C_CNT_W-1:0] cnt_o
);

    (* ASYNC_REG = "TRUE" *) logic [C_SYNC_STAGES-1:0] sync_q;
    logic hist_q;
    logic pulse_q, pulse_d;
    logic sts_q, sts_d;
    logic ovf_q, ovf_d;

    // Outside RUN the history flop still follows the chain, so a level that
    // was already present at reset release never looks like an event.
    assign pulse_d = run_i & (sync_q[C_SYNC_STAGES-1] ^ hist_q);

    always_comb begin
        sts_d = pulse_q | (sts_q & ~clr_i);
        ovf_d = ~clr_i & (ovf_q | (pulse_q & sts_q));
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            pulse_q <= 1'b0;
            sts_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[C_SYNC_STAGES-2:0], tog_i};
            hist_q  <= sync_q[C_SYNC_STAGES-1];
            pulse_q <= pulse_d;
            sts_q   <= sts_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pulse_o = pulse_q;
    assign sts_o   = sts_q;
    assign ovf_o   = ovf_q;

`ifdef EVT_SYNC_CNT_EN
    localparam logic [C_CNT_W-1:0] CNT_MAX = '1;

    logic [C_CNT_W-1:0] cnt_q, cnt_d;

    // A clear that coincides with an event keeps that event in the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = C_CNT_W'(pulse_q);
        end else if (pulse_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + C_CNT_W'(1);
        end
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`else
    assign cnt_o = '0;
`endif

endmodule : evt_sync_ch
`default_nettype wire

// File: rtl/evt_sync_rx.sv
`default_nettype none
// ============================================================================
// Module      : evt_sync_rx
// Description : Multi-channel toggle-event receiver with priming FSM, irq and
//               counter readback (counters built only with EVT_SYNC_CNT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module evt_sync_rx
    import evt_sync_pkg::*;
#(
    parameter  int C_NUM_CH      = 8,
    parameter  int C_SYNC_STAGES = 2,
    parameter  int C_CNT_W       = 8,
    localparam int SEL_W         = sel_width(C_NUM_CH)
) (
    input  logic                rclk,
    input  logic                rst,
    input  logic [C_NUM_CH-1:0] tog_in,
    input  logic [C_NUM_CH-1:0] clr,
    input  logic [C_NUM_CH-1:0] irq_mask,
    input  logic [SEL_W-1:0]    cnt_sel,
    output logic [C_NUM_CH-1:0] pulse,
    output logic [C_NUM_CH-1:0] sts,
    output logic [C_NUM_CH-1:0] ovf,
    output logic                irq,
    output logic [C_CNT_W-1:0]  cnt_out
);

    localparam int                     STAGES     = clamp_stages(C_SYNC_STAGES);
    localparam logic [PRIME_CNT_W-1:0] PRIME_LAST = PRIME_CNT_W'(prime_len(STAGES) - 1);

    evt_state_e             state_q, state_d;
    logic [PRIME_CNT_W-1:0] prime_cnt_q, prime_cnt_d;
    logic                   run;
    logic                   irq_q;

    logic [C_NUM_CH-1:0]               ch_pulse;
    logic [C_NUM_CH-1:0]               ch_sts;
    logic [C_NUM_CH-1:0]               ch_ovf;
    logic [C_NUM_CH-1:0][C_CNT_W-1:0]  ch_cnt;

    always_ff @(posedge rclk) begin
        if (rst) begin
            state_q     <= ST_PRIME;
            prime_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        case (state_q)
            ST_PRIME: begin
                if (prime_cnt_q == PRIME_LAST) begin
                    state_d     = ST_RUN;
                    prime_cnt_d = '0;
                end else begin
                    prime_cnt_d = prime_cnt_q + PRIME_CNT_W'(1);
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_PRIME;
        endcase
    end

    assign run = (state_q == ST_RUN);

    for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
        evt_sync_ch #(
            .C_SYNC_STAGES (STAGES),
            .C_CNT_W       (C_CNT_W)
        ) u_ch (
            .rclk    (rclk),
            .rst     (rst),
            .run_i   (run),
            .tog_i   (tog_in[i]),
            .clr_i   (clr[i]),
            .pulse_o (ch_pulse[i]),
            .sts_o   (ch_sts[i]),
            .ovf_o   (ch_ovf[i]),
            .cnt_o   (ch_cnt[i])
        );
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(ch_sts & irq_mask);
        end
    end

    assign pulse = ch_pulse;
    assign sts   = ch_sts;
    assign ovf   = ch_ovf;
    assign irq   = irq_q;

`ifdef EVT_SYNC_CNT_EN
    // Padding to a power of two makes out-of-range selects read as zero.
    logic [(2**SEL_W)-1:0][C_CNT_W-1:0] cnt_pad;
    logic [C_CNT_W-1:0]                 cnt_out_q;

    always_comb begin
        cnt_pad                 = '0;
        cnt_pad[C_NUM_CH-1:0]   = ch_cnt;
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            cnt_out_q <= '0;
        end else begin
            cnt_out_q <= cnt_pad[cnt_sel];
        end
    end

    assign cnt_out = cnt_out_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^{cnt_sel, ch_cnt};
    assign cnt_out    = '0;
`endif

endmodule : evt_sync_rx
`default_nettype wire
